// File: rtl/vnp4_egress_demux.sv
// rtl/vnp4_egress_demux.sv - egress demux from the VNP4 core to QDMA C2H and CMAC TX streams
// SOP metadata picks one output. Beats pass through a 2-entry FIFO tagged per entry; undeliverable packets are dropped and counted.
module vnp4_egress_demux #(
  parameter int NUM_PHYS_FUNC = 1,
  parameter int NUM_CMAC_PORT = 1,
  parameter int DATA_W        = 512
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [DATA_W-1:0]                      s_axis_tdata,
  input  logic [DATA_W/8-1:0]                    s_axis_tkeep,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  output logic                                   s_axis_tready,
  input  logic                                   s_user_valid,
  input  logic [15:0]                            s_user_size,
  input  logic [15:0]                            s_user_src_pf,
  input  logic [15:0]                            s_user_src_cmac,
  input  logic [15:0]                            s_user_dst_pf,
  input  logic [15:0]                            s_user_dst_cmac,
  input  logic [1:0]                             s_user_to_direction,
  output logic [NUM_PHYS_FUNC-1:0][DATA_W-1:0]   m_axis_pf_tdata,
  output logic [NUM_PHYS_FUNC-1:0][DATA_W/8-1:0] m_axis_pf_tkeep,
  output logic [NUM_PHYS_FUNC-1:0]               m_axis_pf_tlast,
  output logic [NUM_PHYS_FUNC-1:0]               m_axis_pf_tvalid,
  input  logic [NUM_PHYS_FUNC-1:0]               m_axis_pf_tready,
  output logic [NUM_PHYS_FUNC-1:0][15:0]         m_axis_pf_tuser_size,
  output logic [NUM_PHYS_FUNC-1:0][15:0]         m_axis_pf_tuser_src,
  output logic [NUM_PHYS_FUNC-1:0][15:0]         m_axis_pf_tuser_dst,
  output logic [NUM_CMAC_PORT-1:0][DATA_W-1:0]   m_axis_cmac_tdata,
  output logic [NUM_CMAC_PORT-1:0][DATA_W/8-1:0] m_axis_cmac_tkeep,
  output logic [NUM_CMAC_PORT-1:0]               m_axis_cmac_tlast,
  output logic [NUM_CMAC_PORT-1:0]               m_axis_cmac_tvalid,
  input  logic [NUM_CMAC_PORT-1:0]               m_axis_cmac_tready,
  output logic [NUM_CMAC_PORT-1:0][15:0]         m_axis_cmac_tuser_size,
  output logic [NUM_CMAC_PORT-1:0][15:0]         m_axis_cmac_tuser_src,
  output logic [NUM_CMAC_PORT-1:0][15:0]         m_axis_cmac_tuser_dst,
  output logic [31:0]                            drop_pkt_cnt
);
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  typedef struct packed {
    logic        is_cmac;
    logic [1:0]  idx;
    logic [15:0] size;
    logic [15:0] src;
    logic [15:0] dst;
  } tgt_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    tgt_t              tgt;
  } entry_t;

  state_t      state_q, state_d;
  tgt_t        tgt_q, tgt_d;
  entry_t      mem_q [2];
  entry_t      mem_d [2];
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        run_q, run_d;

  tgt_t        sop_tgt, cur_tgt;
  logic        sop_drop, in_ready, hs, push, pop;
  entry_t      head, new_e;

  // Each output side reports its own src/dst index pair.
  always_comb begin
    sop_drop     = 1'b1;
    sop_tgt      = '0;
    sop_tgt.size = s_user_size;
    if (s_user_valid && s_user_to_direction == 2'd1 &&
        s_user_dst_pf < 16'(NUM_PHYS_FUNC)) begin
      sop_drop    = 1'b0;
      sop_tgt.idx = s_user_dst_pf[1:0];
      sop_tgt.src = s_user_src_pf;
      sop_tgt.dst = s_user_dst_pf;
    end else if (s_user_valid && s_user_to_direction == 2'd2 &&
                 s_user_dst_cmac < 16'(NUM_CMAC_PORT)) begin
      sop_drop        = 1'b0;
      sop_tgt.is_cmac = 1'b1;
      sop_tgt.idx     = s_user_dst_cmac[1:0];
      sop_tgt.src     = s_user_src_cmac;
      sop_tgt.dst     = s_user_dst_cmac;
    end
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    in_ready = run_q && ((state_q == DROP) || (count_q != 2'd2));
    hs       = s_axis_tvalid && in_ready;
    cur_tgt  = (state_q == IDLE) ? sop_tgt : tgt_q;
    push     = hs && ((state_q == FWD) || (state_q == IDLE && !sop_drop));

    new_e      = '0;
    new_e.data = s_axis_tdata;
    new_e.keep = s_axis_tkeep;
    new_e.last = s_axis_tlast;
    new_e.tgt  = cur_tgt;

    pop                    = 1'b0;
    m_axis_pf_tdata        = '0;
    m_axis_pf_tkeep        = '0;
    m_axis_pf_tlast        = '0;
    m_axis_pf_tvalid       = '0;
    m_axis_pf_tuser_size   = '0;
    m_axis_pf_tuser_src    = '0;
    m_axis_pf_tuser_dst    = '0;
    m_axis_cmac_tdata      = '0;
    m_axis_cmac_tkeep      = '0;
    m_axis_cmac_tlast      = '0;
    m_axis_cmac_tvalid     = '0;
    m_axis_cmac_tuser_size = '0;
    m_axis_cmac_tuser_src  = '0;
    m_axis_cmac_tuser_dst  = '0;
    for (int p = 0; p < NUM_PHYS_FUNC; p++) begin
      m_axis_pf_tvalid[p]     = (count_q != 2'd0) && !head.tgt.is_cmac && (head.tgt.idx == 2'(p));
      m_axis_pf_tdata[p]      = head.data;
      m_axis_pf_tkeep[p]      = head.keep;
      m_axis_pf_tlast[p]      = head.last;
      m_axis_pf_tuser_size[p] = head.tgt.size;
      m_axis_pf_tuser_src[p]  = head.tgt.src;
      m_axis_pf_tuser_dst[p]  = head.tgt.dst;
      pop = pop | (m_axis_pf_tvalid[p] & m_axis_pf_tready[p]);
    end
    for (int c = 0; c < NUM_CMAC_PORT; c++) begin
      m_axis_cmac_tvalid[c]     = (count_q != 2'd0) && head.tgt.is_cmac && (head.tgt.idx == 2'(c));
      m_axis_cmac_tdata[c]      = head.data;
      m_axis_cmac_tkeep[c]      = head.keep;
      m_axis_cmac_tlast[c]      = head.last;
      m_axis_cmac_tuser_size[c] = head.tgt.size;
      m_axis_cmac_tuser_src[c]  = head.tgt.src;
      m_axis_cmac_tuser_dst[c]  = head.tgt.dst;
      pop = pop | (m_axis_cmac_tvalid[c] & m_axis_cmac_tready[c]);
    end
    s_axis_tready = in_ready;
    drop_pkt_cnt  = drop_cnt_q;
  end

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    drop_cnt_d = drop_cnt_q;
    run_d      = 1'b1;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (hs) begin
      case (state_q)
        IDLE: begin
          tgt_d = sop_tgt;
          if (sop_drop && drop_cnt_q != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_q + 32'd1;
          if (!s_axis_tlast) state_d = sop_drop ? DROP : FWD;
        end
        default: if (s_axis_tlast) state_d = IDLE;
      endcase
    end
    if (push) begin
      mem_d[wr_ptr_q] = new_e;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      drop_cnt_q <= '0;
      run_q      <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      drop_cnt_q <= drop_cnt_d;
      run_q      <= run_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end
endmodule

// File: tb/tb_vnp4_egress_demux.sv
// tb/tb_vnp4_egress_demux.sv - bench for vnp4_egress_demux
// Packet-level reference model with per-port expected-beat queues.
module tb_vnp4_egress_demux;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic        s_uv = 1'b0;
  logic [15:0] size = '0, src_pf = '0, src_cmac = '0, dst_pf = '0, dst_cmac = '0;
  logic [1:0]  dir = '0;

  logic [0:0][63:0] pf_tdata;
  logic [0:0][7:0]  pf_tkeep;
  logic [0:0]       pf_tlast, pf_tvalid;
  logic [0:0]       pf_tready = 1'b1;
  logic [0:0][15:0] pf_size, pf_src, pf_dst;
  logic [1:0][63:0] cm_tdata;
  logic [1:0][7:0]  cm_tkeep;
  logic [1:0]       cm_tlast, cm_tvalid;
  logic [1:0]       cm_tready = 2'b11;
  logic [1:0][15:0] cm_size, cm_src, cm_dst;
  logic [31:0]      drop_pkt_cnt;

  vnp4_egress_demux #(.NUM_PHYS_FUNC(1), .NUM_CMAC_PORT(2), .DATA_W(64)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .s_user_valid(s_uv), .s_user_size(size), .s_user_src_pf(src_pf),
    .s_user_src_cmac(src_cmac), .s_user_dst_pf(dst_pf), .s_user_dst_cmac(dst_cmac),
    .s_user_to_direction(dir),
    .m_axis_pf_tdata(pf_tdata), .m_axis_pf_tkeep(pf_tkeep), .m_axis_pf_tlast(pf_tlast),
    .m_axis_pf_tvalid(pf_tvalid), .m_axis_pf_tready(pf_tready),
    .m_axis_pf_tuser_size(pf_size), .m_axis_pf_tuser_src(pf_src), .m_axis_pf_tuser_dst(pf_dst),
    .m_axis_cmac_tdata(cm_tdata), .m_axis_cmac_tkeep(cm_tkeep), .m_axis_cmac_tlast(cm_tlast),
    .m_axis_cmac_tvalid(cm_tvalid), .m_axis_cmac_tready(cm_tready),
    .m_axis_cmac_tuser_size(cm_size), .m_axis_cmac_tuser_src(cm_src), .m_axis_cmac_tuser_dst(cm_dst),
    .drop_pkt_cnt(drop_pkt_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output readiness: 0 = always ready, 1 = random, 2 = PF0 follows 1,0,0,1.
  int         rdy_mode = 0;
  int         pidx = 0;
  logic [3:0] pat = 4'b1001;
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      1: begin pf_tready = 1'($urandom); cm_tready = 2'($urandom); pidx = 0; end
      2: begin pf_tready[0] = pat[pidx]; cm_tready = 2'b11; pidx = (pidx + 1) % 4; end
      default: begin pf_tready = 1'b1; cm_tready = 2'b11; pidx = 0; end
    endcase
  end

  typedef struct {
    logic [63:0] d;
    logic [56:0] u;
  } beat_t;

  beat_t       expq [3][$];
  int          pending = 0;
  int          tport = 0;
  bit          in_pkt = 1'b0, in_drop = 1'b0, skip = 1'b1;
  bit          stall [3];
  logic [15:0] tsize = '0, tsrc = '0, tdst = '0;
  logic [63:0] drop_seen = '0;
  logic [63:0] drop_base = '0;

  // Model: port 0 = PF0, ports 1/2 = CMAC0/1; the FIFO holds at most two beats.
  always @(negedge aclk) begin
    logic        v, r;
    logic [63:0] od, dexp;
    logic [56:0] ou;
    beat_t       eb;
    if (areset) begin
      for (int p = 0; p < 3; p++) begin expq[p].delete(); stall[p] = 1'b0; end
      pending = 0; in_pkt = 1'b0; in_drop = 1'b0; drop_seen = '0; skip = 1'b1;
    end else begin
      dexp = drop_base + drop_seen;
      if (dexp > 64'h0000_0000_FFFF_FFFF) dexp = 64'h0000_0000_FFFF_FFFF;
      chk("drop_pkt_cnt", 64'(drop_pkt_cnt), dexp);
      if (skip) skip = 1'b0;
      else chk("s_axis_tready", 64'(s_tready), 64'((in_pkt && in_drop) || pending < 2));
      for (int p = 0; p < 3; p++) begin
        case (p)
          0: begin v = pf_tvalid[0]; r = pf_tready[0]; od = pf_tdata[0];
                   ou = {pf_tkeep[0], pf_tlast[0], pf_size[0], pf_src[0], pf_dst[0]}; end
          1: begin v = cm_tvalid[0]; r = cm_tready[0]; od = cm_tdata[0];
                   ou = {cm_tkeep[0], cm_tlast[0], cm_size[0], cm_src[0], cm_dst[0]}; end
          default: begin v = cm_tvalid[1]; r = cm_tready[1]; od = cm_tdata[1];
                   ou = {cm_tkeep[1], cm_tlast[1], cm_size[1], cm_src[1], cm_dst[1]}; end
        endcase
        if (stall[p]) chk($sformatf("hold_valid_p%0d", p), 64'(v), 64'd1);
        if (v) begin
          if (expq[p].size() == 0) chk($sformatf("unexpected_valid_p%0d", p), 64'(v), 64'd0);
          else begin
            eb = expq[p][0];
            chk($sformatf("data_p%0d", p), od, eb.d);
            chk($sformatf("user_p%0d", p), 64'(ou), 64'(eb.u));
            if (r) begin void'(expq[p].pop_front()); pending--; end
          end
        end
        stall[p] = v && !r;
      end
      if (s_tvalid && s_tready) begin
        if (!in_pkt) begin
          in_drop = 1'b1; tsize = size;
          if (s_uv && dir == 2'd1 && dst_pf < 16'd1) begin
            in_drop = 1'b0; tport = 0; tsrc = src_pf; tdst = dst_pf;
          end else if (s_uv && dir == 2'd2 && dst_cmac < 16'd2) begin
            in_drop = 1'b0; tport = 1 + int'(dst_cmac); tsrc = src_cmac; tdst = dst_cmac;
          end
          if (in_drop) drop_seen = drop_seen + 64'd1;
        end
        if (!in_drop) begin
          eb.d = s_tdata;
          eb.u = {s_tkeep, s_tlast, tsize, tsrc, tdst};
          expq[tport].push_back(eb);
          pending++;
        end
        in_pkt = !s_tlast;
      end
    end
  end

  // Sends beats 0..nsend-1 of an nb-beat packet; waits accumulates stalled cycles.
  task automatic send_pkt(input int nb, input int nsend, input bit uv, input logic [1:0] d,
                          input logic [15:0] dpf, input logic [15:0] dcm, input logic [15:0] sz,
                          output int waits);
    int w;
    waits = 0;
    for (int b = 0; b < nsend; b++) begin
      s_tdata = {$urandom, $urandom};
      s_tlast = (b == nb - 1);
      s_tkeep = (b == nb - 1) ? 8'($urandom_range(1, 255)) : 8'hFF;
      if (b == 0) begin
        s_uv = uv; dir = d; dst_pf = dpf; dst_cmac = dcm; size = sz;
      end else begin
        s_uv = 1'($urandom); dir = 2'($urandom); dst_pf = 16'($urandom);
        dst_cmac = 16'($urandom); size = 16'($urandom);
      end
      src_pf = 16'($urandom); src_cmac = 16'($urandom);
      s_tvalid = 1'b1;
      w = 0;
      @(negedge aclk);
      while (!s_tready && w < 300) begin @(negedge aclk); w++; end
      if (w >= 300) chk("input_timeout", 64'(s_tready), 64'd1);
      waits += w;
      @(posedge aclk); #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (pending != 0 && n < 500) begin @(posedge aclk); n++; end
    @(posedge aclk); #1;
    chk("drain_pending", 64'(pending), 64'd0);
  endtask

  initial begin
    int          w, nb, sel;
    logic [1:0]  d;
    logic [15:0] dpf, dcm;
    #3;
    chk("rst_valid", 64'({pf_tvalid, cm_tvalid}), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_drop_cnt", 64'(drop_pkt_cnt), 64'd0);
    chk("rst_data", pf_tdata[0] | cm_tdata[0] | cm_tdata[1], 64'd0);
    @(posedge aclk); #2 areset = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;

    // 3-beat packet to PF0, registered one-cycle latency
    send_pkt(3, 1, 1'b1, 2'd1, 16'd0, 16'd0, 16'd150, w);
    chk("lat_pf0_valid", 64'(pf_tvalid[0]), 64'd1);
    chk("lat_pf0_size", 64'(pf_size[0]), 64'd150);
    s_tvalid = 1'b1;
    send_pkt(3, 3, 1'b1, 2'd1, 16'd0, 16'd0, 16'd150, w);
    drain();

    // 1-beat to CMAC1 then 4-beat to PF0 with no input gap
    send_pkt(1, 1, 1'b1, 2'd2, 16'd0, 16'd1, 16'd64, w);
    chk("b2b_cmac_waits", 64'(w), 64'd0);
    send_pkt(4, 4, 1'b1, 2'd1, 16'd0, 16'd0, 16'd256, w);
    chk("b2b_pf_waits", 64'(w), 64'd0);
    drain();

    // four kinds of drop
    send_pkt(2, 2, 1'b1, 2'd0, 16'd0, 16'd0, 16'd10, w);
    chk("drop_dir0_waits", 64'(w), 64'd0);
    send_pkt(2, 2, 1'b1, 2'd3, 16'd0, 16'd0, 16'd10, w);
    send_pkt(2, 2, 1'b1, 2'd1, 16'd5, 16'd0, 16'd10, w);
    send_pkt(2, 2, 1'b0, 2'd1, 16'd0, 16'd0, 16'd10, w);
    chk("drop_novalid_waits", 64'(w), 64'd0);
    @(posedge aclk); #1;
    chk("drop_cnt_4", 64'(drop_pkt_cnt), 64'd4);

    // PF0 stalls 1,0,0,1 across an 8-beat packet
    rdy_mode = 2;
    send_pkt(8, 8, 1'b1, 2'd1, 16'd0, 16'd0, 16'd512, w);
    chk("stall_backpressure", 64'(w > 0), 64'd1);
    drain();
    rdy_mode = 0;
    drain();

    // reset during beat 2 of a 5-beat packet
    send_pkt(5, 1, 1'b1, 2'd1, 16'd0, 16'd0, 16'd300, w);
    s_tdata = 64'hDEAD_BEEF_0000_0002; s_tlast = 1'b0; s_tvalid = 1'b1;
    #2 areset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'({pf_tvalid, cm_tvalid}), 64'd0);
    chk("mid_rst_tready", 64'(s_tready), 64'd0);
    chk("mid_rst_drop_cnt", 64'(drop_pkt_cnt), 64'd0);
    @(posedge aclk); #2 areset = 1'b0; s_tvalid = 1'b0;
    @(posedge aclk); #1;
    send_pkt(2, 2, 1'b1, 2'd2, 16'd0, 16'd0, 16'd100, w);
    drain();

    // randomized traffic with random output backpressure
    rdy_mode = 1;
    for (int k = 0; k < 60; k++) begin
      nb  = $urandom_range(1, 6);
      sel = $urandom_range(0, 9);
      d   = (sel < 4) ? 2'd1 : ((sel < 8) ? 2'd2 : 2'($urandom));
      sel = $urandom_range(0, 9);
      dpf = (sel < 7) ? 16'd0 : ((sel < 8) ? 16'd1 : 16'h0100);
      dcm = 16'($urandom_range(0, 2));
      send_pkt(nb, nb, ($urandom_range(0, 9) != 0), d, dpf, dcm, 16'($urandom), w);
    end
    rdy_mode = 0;
    drain();

    // saturation of the drop counter
    force dut.drop_cnt_q = 32'hFFFF_FFFE;
    drop_base = 64'hFFFF_FFFE - drop_seen;
    @(posedge aclk); #1;
    release dut.drop_cnt_q;
    @(posedge aclk); #1;
    chk("sat_preset", 64'(drop_pkt_cnt), 64'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) send_pkt(1, 1, 1'b1, 2'd0, 16'd0, 16'd0, 16'd1, w);
    @(posedge aclk); #1;
    chk("sat_drop_cnt", 64'(drop_pkt_cnt), 64'hFFFF_FFFF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
